// File: rtl/uart_pixel_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_pixel_packer_if
// Description : Bundles the pixel FIFO read port and the UART byte handshake
//               used by uart_pixel_packer.
//                 pix_rd_en  - FIFO read request, one-cycle pulse per pixel
//                 pix_data   - FIFO read data, valid the cycle after pix_rd_en
//                 tx_data    - byte to UART
//                 tx_valid   - tx_data valid
//                 tx_ready   - UART accepts byte (transfer = valid & ready)
//               master : packer side; slave : FIFO/UART side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_pixel_packer_if;
  logic        pix_rd_en;
  logic [15:0] pix_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output pix_rd_en,
    output tx_data,
    output tx_valid,
    input  pix_data,
    input  tx_ready
  );

  modport slave (
    input  pix_rd_en,
    input  tx_data,
    input  tx_valid,
    output pix_data,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_pixel_packer
// Description : Reads one frame of H_PIXEL*V_PIXEL RGB565 pixels from the
//               SDRAM read FIFO and sends it to a byte-wide UART as
//               SYNC0, SYNC1, frame index, then each pixel MSB byte first.
//               FIFO reads are paced to the UART handshake.
// Ports       : clk        - clock
//               rst        - synchronous reset, active-high
//               stream_en  - allows a new frame to start (sampled in IDLE)
//               bus        - master modport: FIFO read port + UART byte bus
//               busy       - high from header start to last byte accepted
//               frame_done - one-cycle pulse after the final byte of a frame
//               frame_idx  - index of the current or last frame
// Options     : UART_PIXEL_PACKER_CKSUM_EN - appends an 8-bit sum of all
//               pixel bytes after the last pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pixel_packer #(
  parameter int          H_PIXEL = 640,
  parameter int          V_PIXEL = 480,
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  stream_en,
  uart_pixel_packer_if.master  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_idx
);

  localparam int N     = H_PIXEL * V_PIXEL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HDR0    = 4'd1,
    S_HDR1    = 4'd2,
    S_HDR2    = 4'd3,
    S_RD_REQ  = 4'd4,
    S_RD_WAIT = 4'd5,
    S_BYTE_HI = 4'd6,
    S_BYTE_LO = 4'd7,
    S_CKSUM   = 4'd8,
    S_END     = 4'd9
  } state_t;

  state_t             r_state,    w_state_n;
  logic [15:0]        r_hold,     w_hold_n;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_n;
  logic [7:0]         r_frame_idx, w_idx_n;
  logic [7:0]         r_tx_data,  w_tx_data_n;
  logic               r_tx_valid, w_tx_valid_n;
  logic               r_rd_en,    w_rd_en_n;
  logic               r_busy,     w_busy_n;
  logic               r_done,     w_done_n;
  logic               w_xfer;
`ifdef UART_PIXEL_PACKER_CKSUM_EN
  logic [7:0]         r_sum,      w_sum_n;
`endif

  assign w_xfer        = r_tx_valid & bus.tx_ready;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.pix_rd_en = r_rd_en;
  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign frame_idx     = r_frame_idx;

  // Next-state logic. The registered outputs below are decoded from the
  // next state so they line up with the state they belong to.
  always_comb begin
    w_state_n = r_state;
    w_hold_n  = r_hold;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_frame_idx;
`ifdef UART_PIXEL_PACKER_CKSUM_EN
    w_sum_n   = r_sum;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef UART_PIXEL_PACKER_CKSUM_EN
        w_sum_n = 8'h00;
`endif
        if (stream_en) w_state_n = S_HDR0;
      end
      S_HDR0:    if (w_xfer) w_state_n = S_HDR1;
      S_HDR1:    if (w_xfer) w_state_n = S_HDR2;
      S_HDR2:    if (w_xfer) w_state_n = S_RD_REQ;
      S_RD_REQ:  w_state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        w_hold_n  = bus.pix_data;
        w_state_n = S_BYTE_HI;
      end
      S_BYTE_HI: begin
        if (w_xfer) begin
`ifdef UART_PIXEL_PACKER_CKSUM_EN
          w_sum_n = r_sum + r_tx_data;
`endif
          w_state_n = S_BYTE_LO;
        end
      end
      S_BYTE_LO: begin
        if (w_xfer) begin
`ifdef UART_PIXEL_PACKER_CKSUM_EN
          w_sum_n = r_sum + r_tx_data;
`endif
          if (r_cnt == CNT_W'(N - 1)) begin
`ifdef UART_PIXEL_PACKER_CKSUM_EN
            w_state_n = S_CKSUM;
`else
            w_state_n = S_END;
`endif
          end else begin
            w_cnt_n   = r_cnt + CNT_W'(1);
            w_state_n = S_RD_REQ;
          end
        end
      end
`ifdef UART_PIXEL_PACKER_CKSUM_EN
      S_CKSUM:   if (w_xfer) w_state_n = S_END;
`endif
      S_END: begin
        w_cnt_n   = '0;
        w_idx_n   = r_frame_idx + 8'd1;
        w_state_n = S_IDLE;
      end
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Output decode from the next state. tx_data keeps its last value when
  // no byte is offered so a stalled byte never changes.
  always_comb begin
    w_tx_valid_n = 1'b0;
    w_tx_data_n  = r_tx_data;
    w_rd_en_n    = 1'b0;
    w_done_n     = 1'b0;
    w_busy_n     = 1'b1;
    case (w_state_n)
      S_IDLE:    w_busy_n = 1'b0;
      S_HDR0:    begin w_tx_valid_n = 1'b1; w_tx_data_n = SYNC0;          end
      S_HDR1:    begin w_tx_valid_n = 1'b1; w_tx_data_n = SYNC1;          end
      S_HDR2:    begin w_tx_valid_n = 1'b1; w_tx_data_n = r_frame_idx;    end
      S_RD_REQ:  w_rd_en_n = 1'b1;
      S_BYTE_HI: begin w_tx_valid_n = 1'b1; w_tx_data_n = w_hold_n[15:8]; end
      S_BYTE_LO: begin w_tx_valid_n = 1'b1; w_tx_data_n = w_hold_n[7:0];  end
`ifdef UART_PIXEL_PACKER_CKSUM_EN
      S_CKSUM:   begin w_tx_valid_n = 1'b1; w_tx_data_n = w_sum_n;        end
`endif
      S_END:     begin w_done_n = 1'b1; w_busy_n = 1'b0;                  end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= 16'h0000;
      r_cnt       <= '0;
      r_frame_idx <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef UART_PIXEL_PACKER_CKSUM_EN
      r_sum       <= 8'h00;
`endif
    end else begin
      r_state     <= w_state_n;
      r_hold      <= w_hold_n;
      r_cnt       <= w_cnt_n;
      r_frame_idx <= w_idx_n;
      r_tx_data   <= w_tx_data_n;
      r_tx_valid  <= w_tx_valid_n;
      r_rd_en     <= w_rd_en_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
`ifdef UART_PIXEL_PACKER_CKSUM_EN
      r_sum       <= w_sum_n;
`endif
    end
  end

endmodule
`default_nettype wire
